four_bit_sequential_divider: RTL and testbench

FOUR_BIT_SEQUENTIAL_DIVIDER -- requirements
Module: four_bit_sequential_divider

---
 rtl/four_bit_sequential_divider.sv | 166 ++++++++++++++++
 tb/tb_four_bit_sequential_divider.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/four_bit_sequential_divider.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_sequential_divider
// Description : 4-bit unsigned restoring divider. It produces one quotient bit
//               per RUN cycle, MSB first. The FSM has three states:
//               IDLE, RUN and DONE.
//
//               Busy, Done, Quotient, Remainder and DivZero are registered
//               outputs. They are loaded from the FSM state one edge later,
//               so only finished results ever appear on the outputs.
//               Start accepted at edge N gives:
//                 - Busy high in the cycles following edges N+1..N+4
//                 - Done high in the cycle following edge N+5
//
//               Optional feature, macro DIV_ZERO_DETECT_EN:
//                 - defined   : B == 0 skips RUN. The result is Q=4'hF,
//                               R=A, DivZero=1, with Done one edge after
//                               acceptance.
//                 - undefined : DivZero is tied to 0, and B == 0 runs the
//                               normal algorithm.
//
// Ports       : clk       in   rising-edge clock
//               reset     in   synchronous active-high reset
//               Start     in   division request (accepted in IDLE/DONE)
//               A         in   [3:0] dividend
//               B         in   [3:0] divisor
//               Quotient  out  [3:0] quotient (held until next result)
//               Remainder out  [3:0] remainder (held until next result)
//               Busy      out  iteration in progress
//               Done      out  one-cycle result-valid pulse
//               DivZero   out  divide-by-zero flag, valid with Done
// Revision    : 1.0 - initial release
// ============================================================================
module four_bit_sequential_divider (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Quotient,
  output logic [3:0] Remainder,
  output logic       Busy,
  output logic       Done,
  output logic       DivZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  b_reg;
  logic [4:0]  r_work;
  logic [3:0]  q_work;
  logic [1:0]  count;
  logic        accept;
  logic        zero_skip;
  logic [8:0]  rq_shift;
  logic [4:0]  trial;

  assign accept = Start && ((state == IDLE) || (state == DONE));

`ifdef DIV_ZERO_DETECT_EN
  assign zero_skip = (B == 4'd0);
`else
  assign zero_skip = 1'b0;
`endif

  // One restoring step: shift {R,Q} left, then try to subtract the divisor.
  // If the 5-bit difference is negative (bit 4 set), the subtraction is
  // discarded.
  assign rq_shift = {r_work, q_work} << 1;
  assign trial    = rq_shift[8:4] - {1'b0, b_reg};

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (Start) state_next = zero_skip ? DONE : RUN;
        else       state_next = IDLE;
      end
      RUN: begin
        if (count == 2'd3) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Working datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      b_reg  <= 4'd0;
      r_work <= 5'd0;
      q_work <= 4'd0;
      count  <= 2'd0;
    end else if (accept) begin
      b_reg <= B;
      count <= 2'd0;
      if (zero_skip) begin
        r_work <= {1'b0, A};
        q_work <= 4'hF;
      end else begin
        r_work <= 5'd0;
        q_work <= A;
      end
    end else if (state == RUN) begin
      count <= count + 2'd1;
      if (!trial[4]) begin
        r_work <= trial;
        q_work <= {rq_shift[3:1], 1'b1};
      end else begin
        r_work <= rq_shift[8:4];
        q_work <= {rq_shift[3:1], 1'b0};
      end
    end
  end

  // Registered outputs. They lag the FSM state by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= 4'd0;
      Remainder <= 4'd0;
    end else begin
      Busy <= (state == RUN);
      Done <= (state == DONE);
      if (state == DONE) begin
        Quotient  <= q_work;
        Remainder <= r_work[3:0];
      end
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dz_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      dz_flag <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      if (accept) dz_flag <= zero_skip;
      // Publishing a finished result has priority over clearing the flag.
      // This matters when a new Start is accepted in the same DONE cycle.
      if (state == DONE) DivZero <= dz_flag;
      else if (accept)   DivZero <= 1'b0;
    end
  end
`else
  assign DivZero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_four_bit_sequential_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_four_bit_sequential_divider
// Description : Directed self-checking bench for four_bit_sequential_divider.
//               Inputs are driven on falling edges, and outputs are sampled
//               on falling edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_four_bit_sequential_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Start = 1'b0;
  logic [3:0] A = 4'd0;
  logic [3:0] B = 4'd0;
  logic [3:0] Quotient;
  logic [3:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       DivZero;

  int total = 0;
  int fails = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int accept_cyc = 0;
  int lat;
  int done_seen;

  four_bit_sequential_divider dut (
    .clk(clk), .reset(reset), .Start(Start), .A(A), .B(B),
    .Quotient(Quotient), .Remainder(Remainder),
    .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (Busy) busy_cnt = busy_cnt + 1;

`ifdef DIV_ZERO_DETECT_EN
  localparam int DZ_LAT = 1;
  localparam int DZ_BUSY = 0;
  localparam logic DZ_FLAG = 1'b1;
`else
  localparam int DZ_LAT = 5;
  localparam int DZ_BUSY = 4;
  localparam logic DZ_FLAG = 1'b0;
`endif

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse Start for one cycle. Return at the falling edge after the
  // accepting edge.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    Start = 1'b1; A = a; B = b; busy_cnt = 0;
    @(negedge clk);
    Start = 1'b0;
    accept_cyc = cyc;
  endtask

  // Wait (bounded) for Done. Report the latency in edges after acceptance,
  // or -1 if Done never came.
  task automatic wait_done(output int l);
    l = -1;
    for (int i = 0; i < 20; i++) begin
      if (Done === 1'b1) begin
        l = cyc - accept_cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input int eq, input int er, input int edz,
                       input int elat, input int ebusy);
    int l;
    start_op(a, b);
    wait_done(l);
    check({tag, ".lat"}, l, elat);
    check({tag, ".q"}, int'(Quotient), eq);
    check({tag, ".r"}, int'(Remainder), er);
    check({tag, ".dz"}, int'(DivZero), edz);
    check({tag, ".busy"}, busy_cnt, ebusy);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst.q", int'(Quotient), 0);
    check("rst.r", int'(Remainder), 0);
    check("rst.busy", int'(Busy), 0);
    check("rst.done", int'(Done), 0);
    check("rst.dz", int'(DivZero), 0);

    // Start on the first edge after reset deasserts; 13/3
    reset = 1'b0;
    do_op("d13_3", 4'd13, 4'd3, 4, 1, 0, 5, 4);
    @(negedge clk);
    check("d13_3.pulse", int'(Done), 0);

    // Edge values
    do_op("d15_1", 4'd15, 4'd1, 15, 0, 0, 5, 4);
    do_op("d2_7", 4'd2, 4'd7, 0, 2, 0, 5, 4);
    do_op("d0_5", 4'd0, 4'd5, 0, 0, 0, 5, 4);

    // Divide by zero
    do_op("d9_0", 4'd9, 4'd0, 15, 9, int'(DZ_FLAG), DZ_LAT, DZ_BUSY);
    // DivZero clears on the next accepted Start
    do_op("d7_2a", 4'd7, 4'd2, 3, 1, 0, 5, 4);

    // A Start during RUN is ignored. A Start in the Done cycle is accepted.
    start_op(4'd12, 4'd5);
    @(negedge clk);
    Start = 1'b1; A = 4'd15; B = 4'd1;
    @(negedge clk);
    Start = 1'b0;
    wait_done(lat);
    check("ign.lat", lat, 5);
    check("ign.q", int'(Quotient), 2);
    check("ign.r", int'(Remainder), 2);
    do_op("acc15_1", 4'd15, 4'd1, 15, 0, 0, 5, 4);

    // Reset in RUN cycle 3 aborts the operation
    @(negedge clk);
    start_op(4'd13, 4'd3);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.q", int'(Quotient), 0);
    check("abort.r", int'(Remainder), 0);
    check("abort.busy", int'(Busy), 0);
    check("abort.done", int'(Done), 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (Done === 1'b1) done_seen++;
    end
    check("abort.nodone", done_seen, 0);
    do_op("d7_2b", 4'd7, 4'd2, 3, 1, 0, 5, 4);

    // Back-to-back sweep over all nonzero divisors
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        start_op(4'(a), 4'(b));
        wait_done(lat);
        check($sformatf("sw%0d_%0d.lat", a, b), lat, 5);
        check($sformatf("sw%0d_%0d.id", a, b),
              int'(Quotient) * b + int'(Remainder), a);
        check($sformatf("sw%0d_%0d.rlt", a, b), int'(int'(Remainder) < b), 1);
        check($sformatf("sw%0d_%0d.q", a, b), int'(Quotient), a / b);
      end
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
`default_nettype wire
